mars_date_counter: RTL
======================

Name: mars_date_counter

Overview:
- Running Martian calendar date counter: sol-of-month, month (0–23) and year, advanced one sol per `sol_tick` pulse.
- Month length: even months 28 sols; odd months 27 sols; month 23 has 28 sols in a leap year.
- Supports a handshaked date load that validates the date and computes year-mod-10 bit-serially.
- Feeds timestamp and event logic downstream.

Parameters:
- YEAR_W, 12, width of the year counter; year range 0..2^YEAR_W-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- sol_tick  in  1  single-cycle pulse; advance date by one sol
- load_valid  in  1  load request; held until accepted
- load_ready  out  1  high when block accepts a load
- load_sol  in  5  sol to load, 1-based
- load_month  in  5  month to load, 0..23
- load_year  in  YEAR_W  year to load
- sol  out  5  current sol, 1..28
- month  out  5  current month, 0..23
- year  out  YEAR_W  current year
- leap  out  1  current year is a leap year
- month_end  out  1  pulse: the tick just applied rolled the month
- year_end  out  1  pulse: the tick just applied rolled the year
- load_done  out  1  pulse: load committed
- load_err  out  1  pulse: load rejected (invalid date)
- tick_lost  out  1  pulse: `sol_tick` arrived while busy and was dropped

Behaviour:
- Reset values:
  - Outputs: sol=1, month=0, year=0, leap=1, load_ready=1; all pulses 0.
  - Internal: ymod10=0; state=RUN.
- Clock and reset: one clock; reset is synchronous and active-high, on clk and rst. Reset wins over everything, including mid-load; a partial load is discarded.
- Leap rule: leap = year[0] | (ymod10==0). ymod10 is an internal 4-bit register, always equal to year mod 10. No divider is used.
- Month length: len = 28 if month[0]==0 or (month==23 and leap); otherwise 27.
- State RUN:
  - load_ready=1.
  - On sol_tick with sol<len: sol+1.
  - On sol_tick with sol==len: sol=1, month_end=1, month+1.
  - If month was 23: month=0, year_end=1, year+1, ymod10 = (ymod10==9)?0:ymod10+1.
  - Year at 2^YEAR_W-1 wraps to 0 with ymod10=0.
  - All of these updates occur in the cycle after the tick; pulses are registered and aligned with the new date.
- RUN with load_valid: handshake in the same cycle (load_valid & load_ready).
  - Capture load_* into shadow registers; go to DIV.
  - A sol_tick in the accept cycle is dropped and tick_lost=1. Load has priority.
- State DIV:
  - load_ready=0.
  - Restoring remainder of shadow year by 10, one bit per cycle, MSB first, YEAR_W cycles; bit counter counts down.
  - Then go to CHK.
- State CHK (1 cycle):
  - Valid iff 1<=load_sol, load_month<=23, and load_sol<=len computed from the shadow month, shadow year[0] and the new remainder.
  - Valid: commit sol/month/year/ymod10 and pulse load_done.
  - Invalid: current date unchanged, load_err=1.
  - Either way, return to RUN.
- Load latency: accept cycle, then YEAR_W DIV cycles, then CHK. New date is visible YEAR_W+2 cycles after accept.
- sol_tick in DIV or CHK: dropped, tick_lost=1 that cycle. Date is not advanced.
- load_valid in DIV or CHK: ignored (load_ready=0). The requester must hold it.
- Outputs are registers; leap is derived combinationally from registered year[0]/ymod10.

Optional Feature:
- Macro: MARS_DATE_ALARM_EN.
- Defined:
  - Adds ports alarm_set (in 1), alarm_month (in 5), alarm_sol (in 5), alarm (out 1).
  - alarm_set latches the alarm registers; no alarm is armed at reset.
  - alarm pulses one cycle when a tick-driven update makes (month,sol) equal the armed value, in every year.
  - Load commits never fire alarm.
- Undefined: ports and registers absent; all other behaviour identical.

Test Plan:
- Reset, then check outputs → sol=1, month=0, year=0, leap=1, load_ready=1.
- 28 ticks from reset → after 27: sol=28, month=0; 28th: sol=1, month=1, month_end=1. Then 27 more ticks → month=2, sol=1.
- Year 2 (non-leap):
  - Load sol=27 month=23 year=2, then 1 tick → sol=1, month=0, year=3, year_end=1, leap=1.
  - Then load sol=28 month=23 year=2 → load_err=1, date unchanged.
- Year 20 (leap via mod 10):
  - Load sol=28 month=23 year=20 → load_done after 14 cycles (YEAR_W=12), leap=1.
  - 1 tick → year=21, sol=1, month=0.
  - Load year=22 → leap=0.
- Tick during DIV → tick_lost=1, date after commit equals the loaded date exactly. Assert rst mid-DIV → reset values, state RUN.
- Year wrap:
  - Load sol=27 month=23 year=4095; 4095 is odd, so leap=1 and month 23 has 28 sols. 1 tick → sol=28, month=23, year=4095.
  - 1 more tick → year=0, leap=1, year_end=1.
  - With MARS_DATE_ALARM_EN: arm (5,10), tick through → alarm pulses exactly once at month=5 sol=10.

Source files
------------

// File: rtl/mars_date_counter.sv
// -----------------------------------------------------------------------------
// mars_date_counter
//   Running Martian calendar date: sol (1..28), month (0..23) and year.
//   Each sol_tick advances the date by one sol. A handshaked load writes a new
//   date. Before committing it, the block works out year mod 10 one bit per
//   cycle and then checks that the date is valid.
//
//   Optional build macro: MARS_DATE_ALARM_EN adds an armable (month,sol) alarm.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   sol_tick          advance one sol (dropped while a load is in flight)
//   load_valid/ready  load handshake; load_sol/month/year carry the date
//   sol/month/year    current date (registered)
//   leap              current year is a leap year
//   month_end         pulse: the last tick rolled the month
//   year_end          pulse: the last tick rolled the year
//   load_done         pulse: load committed
//   load_err          pulse: load rejected as an invalid date
//   tick_lost         pulse: a tick arrived while busy and was dropped
//   alarm_set/month/sol, alarm   (MARS_DATE_ALARM_EN only)
// -----------------------------------------------------------------------------
module mars_date_counter #(
   parameter int YEAR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sol_tick,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [4:0]        load_sol,
   input  logic [4:0]        load_month,
   input  logic [YEAR_W-1:0] load_year,
   output logic [4:0]        sol,
   output logic [4:0]        month,
   output logic [YEAR_W-1:0] year,
   output logic              leap,
   output logic              month_end,
   output logic              year_end,
   output logic              load_done,
   output logic              load_err,
`ifdef MARS_DATE_ALARM_EN
   input  logic              alarm_set,
   input  logic [4:0]        alarm_month,
   input  logic [4:0]        alarm_sol,
   output logic              alarm,
`endif
   output logic              tick_lost
);

   localparam int CNT_W = (YEAR_W > 1) ? $clog2(YEAR_W) : 1;
   localparam logic [YEAR_W-1:0] YEAR_ONE = {{(YEAR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {RUN, DIV, CHK} state_t;

   state_t            state_q, state_d;
   logic [4:0]        sol_q, sol_d, month_q, month_d;
   logic [YEAR_W-1:0] year_q, year_d;
   logic [3:0]        ymod10_q, ymod10_d;
   logic              month_end_q, month_end_d, year_end_q, year_end_d;
   logic              load_done_q, load_done_d, load_err_q, load_err_d;
   logic              tick_lost_q, tick_lost_d;
   logic [4:0]        sh_sol_q, sh_sol_d, sh_month_q, sh_month_d;
   logic [YEAR_W-1:0] sh_year_q, sh_year_d;
   logic [3:0]        rem_q, rem_d;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d;
`ifdef MARS_DATE_ALARM_EN
   logic              alm_arm_q, alm_arm_d, alarm_q, alarm_d;
   logic [4:0]        alm_month_q, alm_month_d, alm_sol_q, alm_sol_d;
`endif

   logic       cur_leap, sh_leap;
   logic [4:0] cur_len, sh_len;
   logic [4:0] rem_t;

   function automatic logic [4:0] month_len(input logic [4:0] m, input logic lp);
      return (!m[0] || (m == 5'd23 && lp)) ? 5'd28 : 5'd27;
   endfunction

   assign cur_leap = year_q[0] | (ymod10_q == 4'd0);
   assign cur_len  = month_len(month_q, cur_leap);
   // Leap flag and month length of the date being loaded; valid only in CHK,
   // once rem_q holds the shadow year mod 10.
   assign sh_leap  = sh_year_q[0] | (rem_q == 4'd0);
   assign sh_len   = month_len(sh_month_q, sh_leap);
   // One restoring step: shift the next year bit (MSB first) into the remainder.
   assign rem_t    = {rem_q, sh_year_q[bcnt_q]};

   always_comb begin
      state_d     = state_q;
      sol_d       = sol_q;
      month_d     = month_q;
      year_d      = year_q;
      ymod10_d    = ymod10_q;
      month_end_d = 1'b0;
      year_end_d  = 1'b0;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      tick_lost_d = 1'b0;
      sh_sol_d    = sh_sol_q;
      sh_month_d  = sh_month_q;
      sh_year_d   = sh_year_q;
      rem_d       = rem_q;
      bcnt_d      = bcnt_q;
`ifdef MARS_DATE_ALARM_EN
      alm_arm_d   = alm_arm_q | alarm_set;
      alm_month_d = alarm_set ? alarm_month : alm_month_q;
      alm_sol_d   = alarm_set ? alarm_sol   : alm_sol_q;
      alarm_d     = 1'b0;
`endif
      case (state_q)
         RUN: begin
            if (load_valid) begin
               // A load wins over a tick that arrives in the same cycle.
               sh_sol_d    = load_sol;
               sh_month_d  = load_month;
               sh_year_d   = load_year;
               rem_d       = 4'd0;
               bcnt_d      = CNT_W'(YEAR_W - 1);
               tick_lost_d = sol_tick;
               state_d     = DIV;
            end else if (sol_tick) begin
               if (sol_q < cur_len) begin
                  sol_d = sol_q + 5'd1;
               end else begin
                  sol_d       = 5'd1;
                  month_end_d = 1'b1;
                  if (month_q == 5'd23) begin
                     month_d    = 5'd0;
                     year_end_d = 1'b1;
                     year_d     = year_q + YEAR_ONE;
                     // Wrapping the year to 0 forces ymod10 back to 0 as well.
                     if (year_q == {YEAR_W{1'b1}} || ymod10_q == 4'd9)
                        ymod10_d = 4'd0;
                     else
                        ymod10_d = ymod10_q + 4'd1;
                  end else begin
                     month_d = month_q + 5'd1;
                  end
               end
`ifdef MARS_DATE_ALARM_EN
               alarm_d = alm_arm_q && (month_d == alm_month_q) && (sol_d == alm_sol_q);
`endif
            end
         end
         DIV: begin
            tick_lost_d = sol_tick;
            rem_d       = (rem_t >= 5'd10) ? 4'(rem_t - 5'd10) : rem_t[3:0];
            bcnt_d      = bcnt_q - CNT_W'(1);
            if (bcnt_q == '0) state_d = CHK;
         end
         CHK: begin
            tick_lost_d = sol_tick;
            if (sh_sol_q != 5'd0 && sh_month_q <= 5'd23 && sh_sol_q <= sh_len) begin
               sol_d       = sh_sol_q;
               month_d     = sh_month_q;
               year_d      = sh_year_q;
               ymod10_d    = rem_q;
               load_done_d = 1'b1;
            end else begin
               load_err_d  = 1'b1;
            end
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         sol_q       <= 5'd1;
         month_q     <= 5'd0;
         year_q      <= '0;
         ymod10_q    <= 4'd0;
         month_end_q <= 1'b0;
         year_end_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         tick_lost_q <= 1'b0;
         sh_sol_q    <= 5'd0;
         sh_month_q  <= 5'd0;
         sh_year_q   <= '0;
         rem_q       <= 4'd0;
         bcnt_q      <= '0;
`ifdef MARS_DATE_ALARM_EN
         alm_arm_q   <= 1'b0;
         alm_month_q <= 5'd0;
         alm_sol_q   <= 5'd0;
         alarm_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sol_q       <= sol_d;
         month_q     <= month_d;
         year_q      <= year_d;
         ymod10_q    <= ymod10_d;
         month_end_q <= month_end_d;
         year_end_q  <= year_end_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
         tick_lost_q <= tick_lost_d;
         sh_sol_q    <= sh_sol_d;
         sh_month_q  <= sh_month_d;
         sh_year_q   <= sh_year_d;
         rem_q       <= rem_d;
         bcnt_q      <= bcnt_d;
`ifdef MARS_DATE_ALARM_EN
         alm_arm_q   <= alm_arm_d;
         alm_month_q <= alm_month_d;
         alm_sol_q   <= alm_sol_d;
         alarm_q     <= alarm_d;
`endif
      end
   end

   assign load_ready = (state_q == RUN);
   assign sol        = sol_q;
   assign month      = month_q;
   assign year       = year_q;
   assign leap       = cur_leap;
   assign month_end  = month_end_q;
   assign year_end   = year_end_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;
   assign tick_lost  = tick_lost_q;
`ifdef MARS_DATE_ALARM_EN
   assign alarm      = alarm_q;
`endif

endmodule
